// File: rtl/vc_ext_bus_bridge_if.sv
// CPU memory port plus external multiplexed 8-bit bus signals of vc_ext_bus_bridge.
// VC_BUS_READY_EN adds the bus_ready input from the pins.
interface vc_ext_bus_bridge_if #(
    parameter int RV        = 32,
    parameter int ADDR_BITS = 16
);
    localparam int NB = RV / 8;
    localparam int LG = $clog2(NB);
    localparam int NA = ADDR_BITS / 8;

    // CPU side: a request is any nonzero mask; rdone/wdone pulse once per accepted request.
    logic [RV-LG-1:0] raddr;
    logic [NB-1:0]    rreq;
    logic [RV-1:0]    rdata;
    logic             rdone;
    logic [RV-LG-1:0] waddr;
    logic [NB-1:0]    wmask;
    logic [RV-1:0]    wdata;
    logic             wdone;
    logic [7:0]       bus_out;
    logic [7:0]       bus_in;
    logic [NA-1:0]    bus_latch;
    logic             bus_write;
    logic [LG-1:0]    bus_lane;
`ifdef VC_BUS_READY_EN
    logic             bus_ready;

    modport slave (
        input  raddr, rreq, waddr, wmask, wdata, bus_in, bus_ready,
        output rdata, rdone, wdone, bus_out, bus_latch, bus_write, bus_lane
    );
    modport master (
        output raddr, rreq, waddr, wmask, wdata, bus_in, bus_ready,
        input  rdata, rdone, wdone, bus_out, bus_latch, bus_write, bus_lane
    );
`else
    modport slave (
        input  raddr, rreq, waddr, wmask, wdata, bus_in,
        output rdata, rdone, wdone, bus_out, bus_latch, bus_write, bus_lane
    );
    modport master (
        output raddr, rreq, waddr, wmask, wdata, bus_in,
        input  rdata, rdone, wdone, bus_out, bus_latch, bus_write, bus_lane
    );
`endif
endinterface

// File: rtl/vc_ext_bus_bridge.sv
// Bridge from the vc CPU memory port to an 8-bit multiplexed address/data bus with latch strobes.
// Optional feature macro VC_BUS_READY_EN: beats stretch while bus_ready is low.
module vc_ext_bus_bridge #(
    parameter int RV          = 32,
    parameter int ADDR_BITS   = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  reset_in,
    input  logic                  ena,
    vc_ext_bus_bridge_if.slave    io,
    output logic [1:0]            dbg_state
);
    localparam int NB = RV / 8;
    localparam int LG = $clog2(NB);
    localparam int NA = ADDR_BITS / 8;
    localparam int PW = (NA > 1) ? $clog2(NA) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

    state_t                 state, state_d;
    logic [PW-1:0]          phase;
    logic [LG-1:0]          lane;
    logic [3:0]             wcnt;
    logic                   is_wr;
    logic [NB-1:0]          mask_r;
    logic [ADDR_BITS-1:0]   addr_r;
    logic [RV-1:0]          wdata_r;
    logic [RV-1:0]          rdata_r;

    logic                   take_wr, accept, beat_end, ready;
    logic [LG:0]            first_lane, next_lane;
    logic [RV+ADDR_BITS-1:0] addr_ext;

    // Returns {found, index} of the lowest set mask bit at or above 'from'.
    function automatic logic [LG:0] find_lane(input logic [NB-1:0] m, input int from);
        logic [LG:0] r;
        r = '0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (m[i] && i >= from) r = {1'b1, LG'(i)};
        end
        return r;
    endfunction

`ifdef VC_BUS_READY_EN
    assign ready = io.bus_ready;
`else
    assign ready = 1'b1;
`endif

    assign io.rdata  = rdata_r;
    assign dbg_state = state;

    always_comb begin
        take_wr      = |io.wmask;
        accept       = take_wr | (|io.rreq);
        // Word address becomes a byte address on the external bus.
        addr_ext     = take_wr ? {{ADDR_BITS{1'b0}}, io.waddr, {LG{1'b0}}}
                               : {{ADDR_BITS{1'b0}}, io.raddr, {LG{1'b0}}};
        first_lane   = find_lane(mask_r, 0);
        next_lane    = find_lane(mask_r, int'(lane) + 1);
        beat_end     = (wcnt == 4'(WAIT_CYCLES)) && ready;
        state_d      = state;
        io.bus_out   = '0;
        io.bus_latch = '0;
        io.bus_write = 1'b0;
        io.bus_lane  = '0;
        io.rdone     = 1'b0;
        io.wdone     = 1'b0;
        case (state)
            S_IDLE: if (accept) state_d = S_ADDR;
            S_ADDR: begin
                io.bus_out   = addr_r[{phase, 3'b000} +: 8];
                io.bus_latch = NA'(1) << phase;
                if (phase == '0) state_d = S_DATA;
            end
            S_DATA: begin
                io.bus_lane  = lane;
                io.bus_write = is_wr;
                if (is_wr) io.bus_out = wdata_r[{lane, 3'b000} +: 8];
                if (beat_end) state_d = next_lane[LG] ? S_DATA : S_DONE;
            end
            S_DONE: begin
                io.rdone = ~is_wr;
                io.wdone = is_wr;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            state   <= S_IDLE;
            phase   <= '0;
            lane    <= '0;
            wcnt    <= '0;
            is_wr   <= 1'b0;
            mask_r  <= '0;
            addr_r  <= '0;
            wdata_r <= '0;
            rdata_r <= '0;
        end else if (ena) begin
            state <= state_d;
            case (state)
                S_IDLE: if (accept) begin
                    is_wr   <= take_wr;
                    mask_r  <= take_wr ? io.wmask : io.rreq;
                    addr_r  <= addr_ext[ADDR_BITS-1:0];
                    wdata_r <= io.wdata;
                    phase   <= PW'(NA - 1);
                    if (!take_wr) rdata_r <= '0;
                end
                S_ADDR: begin
                    phase <= phase - 1'b1;
                    if (phase == '0) begin
                        lane <= first_lane[LG-1:0];
                        wcnt <= '0;
                    end
                end
                S_DATA: begin
                    if (beat_end) begin
                        if (!is_wr) rdata_r[{lane, 3'b000} +: 8] <= io.bus_in;
                        lane <= next_lane[LG-1:0];
                        wcnt <= '0;
                    end else if (wcnt != 4'(WAIT_CYCLES)) begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vc_ext_bus_bridge.sv
// Directed bench for vc_ext_bus_bridge: 16-bit/no-wait and 32-bit/2-wait instances.
module tb_vc_ext_bus_bridge;
    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [1:0] dbg_a, dbg_b;

    always #5 clk = ~clk;

    vc_ext_bus_bridge_if #(.RV(16), .ADDR_BITS(16)) ifa ();
    vc_ext_bus_bridge_if #(.RV(32), .ADDR_BITS(16)) ifb ();

    vc_ext_bus_bridge #(.RV(16), .ADDR_BITS(16), .WAIT_CYCLES(0)) dut_a (
        .clk(clk), .reset_in(rst), .ena(ena), .io(ifa), .dbg_state(dbg_a));
    vc_ext_bus_bridge #(.RV(32), .ADDR_BITS(16), .WAIT_CYCLES(2)) dut_b (
        .clk(clk), .reset_in(rst), .ena(ena), .io(ifb), .dbg_state(dbg_b));

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifa.rreq = '0; ifa.wmask = '0; ifa.raddr = '0; ifa.waddr = '0; ifa.wdata = '0; ifa.bus_in = '0;
        ifb.rreq = '0; ifb.wmask = '0; ifb.raddr = '0; ifb.waddr = '0; ifb.wdata = '0; ifb.bus_in = '0;
`ifdef VC_BUS_READY_EN
        ifa.bus_ready = 1'b1;
        ifb.bus_ready = 1'b1;
`endif
    endtask

    initial begin
        int wd, rd, cyc, dones;
        bit bad;
        clear_inputs();
        ena = 1'b1;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        check("rst_a_out", {ifa.bus_out, ifa.bus_latch, 1'(ifa.bus_write), ifa.bus_lane}, 0);
        check("rst_a_done", {ifa.rdone, ifa.wdone, ifa.rdata}, 0);
        check("rst_a_state", dbg_a, 0);
        check("rst_b_out", {ifb.bus_out, ifb.bus_latch, 1'(ifb.bus_write), ifb.bus_lane}, 0);
        check("rst_b_state", dbg_b, 0);

        // Two-lane write; latch bytes are the byte address {waddr,0} = 16'h2468.
        ifa.wmask = 2'b11; ifa.waddr = 15'h1234; ifa.wdata = 16'hBEEF;
        step();
        ifa.wmask = '0; ifa.wdata = 16'h0000;
        check("aw_c1", {ifa.bus_out, 6'(ifa.bus_latch)}, {8'h24, 6'b000010});
        step();
        check("aw_c2", {ifa.bus_out, 6'(ifa.bus_latch)}, {8'h68, 6'b000001});
        step();
        check("aw_c3", {ifa.bus_out, 2'(ifa.bus_latch), ifa.bus_write, ifa.bus_lane}, {8'hEF, 2'b00, 1'b1, 1'b0});
        step();
        check("aw_c4", {ifa.bus_out, 2'(ifa.bus_latch), ifa.bus_write, ifa.bus_lane}, {8'hBE, 2'b00, 1'b1, 1'b1});
        step();
        check("aw_c5_done", {ifa.wdone, ifa.rdone, ifa.bus_write}, 3'b100);
        step();
        check("aw_c6_idle", {ifa.wdone, 2'(dbg_a)}, 3'b000);

        // Single upper-lane read.
        ifa.rreq = 2'b10; ifa.raddr = 15'h0040; ifa.bus_in = 8'h5A;
        step();
        ifa.rreq = '0;
        check("ar_c1", {ifa.bus_out, 6'(ifa.bus_latch)}, {8'h00, 6'b000010});
        step();
        check("ar_c2", {ifa.bus_out, 6'(ifa.bus_latch)}, {8'h80, 6'b000001});
        step();
        check("ar_c3", {ifa.bus_write, ifa.bus_lane, 2'(dbg_a)}, {1'b0, 1'b1, 2'd2});
        step();
        check("ar_c4_done", {ifa.rdone, ifa.wdone}, 2'b10);
        check("ar_rdata", ifa.rdata, 16'h5A00);
        step();

        // Second read must clear the previous rdata on accept.
        ifa.rreq = 2'b01; ifa.raddr = 15'h0001; ifa.bus_in = 8'h3C;
        step();
        ifa.rreq = '0;
        check("ar2_clear", ifa.rdata, 16'h0000);
        step(); step(); step();
        check("ar2_done", ifa.rdone, 1'b1);
        check("ar2_rdata", ifa.rdata, 16'h003C);
        step();

        // Simultaneous write and read: write first, read on the IDLE after wdone.
        ifa.rreq = 2'b01; ifa.wmask = 2'b01; ifa.waddr = 15'h0010; ifa.wdata = 16'h00C3;
        ifa.raddr = 15'h0020; ifa.bus_in = 8'h77;
        wd = -1; rd = -1; bad = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (ifa.wdone && ifa.rdone) bad = 1'b1;
            if (wd >= 0 && ifa.bus_write) bad = 1'b1;
            if (ifa.wdone) begin wd = c; ifa.wmask = '0; end
            if (ifa.rdone) begin rd = c; ifa.rreq = '0; break; end
        end
        check("sim_wdone_cyc", wd, 4);
        check("sim_rdone_cyc", rd, 9);
        check("sim_overlap", bad, 0);
        check("sim_rdata", ifa.rdata, 16'h0077);
        step();

        // Reset during the second address phase aborts without a done pulse.
        ifa.wmask = 2'b11; ifa.waddr = 15'h0005; ifa.wdata = 16'h1111;
        step();
        ifa.wmask = '0;
        step();
        check("rm_phase0", ifa.bus_latch, 2'b01);
        rst = 1'b1;
        step();
        check("rm_out", {ifa.bus_out, ifa.bus_latch, 1'(ifa.bus_write), ifa.bus_lane, ifa.rdata}, 0);
        check("rm_state", dbg_a, 0);
        rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            if (ifa.rdone || ifa.wdone) dones++;
            step();
        end
        check("rm_no_done", dones, 0);

        // ena low for 5 cycles in the middle of the first data beat.
        ifa.wmask = 2'b11; ifa.waddr = 15'h0000; ifa.wdata = 16'hA55A;
        step();
        ifa.wmask = '0;
        step(); step();
        check("fz_c3", {ifa.bus_out, ifa.bus_write, ifa.bus_lane}, {8'h5A, 1'b1, 1'b0});
        ena = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (ifa.bus_out !== 8'h5A || ifa.bus_write !== 1'b1 || ifa.bus_lane !== 1'b0 || ifa.wdone !== 1'b0)
                bad = 1'b1;
        end
        check("fz_held", bad, 0);
        ena = 1'b1;
        cyc = 8;
        for (int k = 0; k < 20; k++) begin
            step();
            cyc++;
            if (ifa.wdone) break;
        end
        check("fz_latency", cyc, 10);
        step();

        // 32-bit, two wait states: beats on lanes 0 and 2, three cycles each.
        ifb.wmask = 4'b0101; ifb.waddr = 30'h0000_0100; ifb.wdata = 32'h1122_3344;
        for (int k = 0; k < 3; k++) exp_q.push_back({5'd0, 1'b1, 2'd0, 8'h44});
        for (int k = 0; k < 3; k++) exp_q.push_back({5'd0, 1'b1, 2'd2, 8'h22});
        step();
        ifb.wmask = '0;
        check("bw_c1", {ifb.bus_out, 4'(ifb.bus_latch)}, {8'h04, 4'b0010});
        step();
        check("bw_c2", {ifb.bus_out, 4'(ifb.bus_latch)}, {8'h00, 4'b0001});
        while (exp_q.size() > 0) begin
            step();
            check("bw_beat", {5'd0, ifb.bus_write, ifb.bus_lane, ifb.bus_out}, exp_q.pop_front());
        end
        step();
        check("bw_done", {ifb.wdone, ifb.rdone, ifb.bus_write}, 3'b100);
        step();

        // 32-bit read of lanes 0 and 3 at the top word; bus_in changes every cycle.
        ifb.rreq = 4'b1001; ifb.raddr = 30'h3FFF_FFFF; ifb.bus_in = 8'h00;
        step();
        ifb.rreq = '0; ifb.bus_in = 8'h11;
        check("br_c1", {ifb.bus_out, 4'(ifb.bus_latch)}, {8'hFF, 4'b0010});
        step();
        ifb.bus_in = 8'h22;
        check("br_c2", {ifb.bus_out, 4'(ifb.bus_latch)}, {8'hFC, 4'b0001});
        bad = 1'b0;
        for (int c = 3; c <= 8; c++) begin
            step();
            ifb.bus_in = 8'(c * 17);
            if (ifb.bus_write !== 1'b0) bad = 1'b1;
        end
        check("br_no_write", bad, 0);
        step();
        check("br_done", {ifb.rdone, ifb.wdone}, 2'b10);
        check("br_rdata", ifb.rdata, 32'h8800_0055);
        step();

`ifdef VC_BUS_READY_EN
        // bus_ready low for three cycles stretches the read beat to four.
        ifa.rreq = 2'b01; ifa.raddr = 15'h0000;
        step();
        ifa.rreq = '0;
        step();
        bad = 1'b0;
        for (int c = 3; c <= 6; c++) begin
            step();
            ifa.bus_ready = (c == 6);
            ifa.bus_in = 8'(c * 17);
            if (dbg_a !== 2'd2) bad = 1'b1;
        end
        check("rdy_in_data", bad, 0);
        step();
        ifa.bus_ready = 1'b1;
        check("rdy_done", ifa.rdone, 1'b1);
        check("rdy_rdata", ifa.rdata, 16'h0066);
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
